// File: rtl/ryg_pwm_sequencer.sv
// Red/green/yellow phase sequencer with tick-based dwell timing and per-light duty outputs.
// Define RYG_FADE_EN to make the active light ramp toward its target by one step per tick.
module ryg_pwm_sequencer #(
    parameter int TICK_DIV = 100000,
    parameter int DUTY_MAX = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] red_time,
    input  logic [15:0] green_time,
    input  logic [15:0] yellow_time,
    input  logic [6:0]  brightness,
    output logic [6:0]  red_duty,
    output logic [6:0]  yellow_duty,
    output logic [6:0]  green_duty,
    output logic [1:0]  state,
    output logic        phase_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RED    = 2'b01,
        GREEN  = 2'b10,
        YELLOW = 2'b11
    } phase_t;

    phase_t      state_q, state_n, nxt;
    logic [26:0] presc_q, presc_n;
    logic [15:0] dwell_q, dwell_n;
    logic [15:0] time_q, time_n, nxt_time, time_eff;
    logic        tick, expire, done_n;
    logic [6:0]  target;
    phase_t      duty_src;
    logic [6:0]  duty_lvl;

    assign tick     = (state_q != IDLE) && (presc_q == 27'(TICK_DIV - 1));
    assign time_eff = (time_q == 16'd0) ? 16'd1 : time_q;
    assign expire   = tick && (dwell_q == time_eff - 16'd1);
    assign target   = (brightness > 7'(DUTY_MAX)) ? 7'(DUTY_MAX) : brightness;
    assign state    = state_q;

    // Phase that follows the current one; IDLE and YELLOW both lead to RED.
    always_comb begin
        nxt      = RED;
        nxt_time = red_time;
        case (state_q)
            RED: begin
                nxt      = GREEN;
                nxt_time = green_time;
            end
            GREEN: begin
                nxt      = YELLOW;
                nxt_time = yellow_time;
            end
            default: begin
                nxt      = RED;
                nxt_time = red_time;
            end
        endcase
    end

    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        dwell_n = dwell_q;
        time_n  = time_q;
        done_n  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            presc_n = '0;
            dwell_n = '0;
            time_n  = '0;
        end else if (state_q == IDLE || expire) begin
            state_n = nxt;
            presc_n = '0;
            dwell_n = '0;
            time_n  = nxt_time;
            done_n  = (state_q != IDLE);
        end else begin
            presc_n = tick ? 27'd0 : presc_q + 27'd1;
            dwell_n = tick ? dwell_q + 16'd1 : dwell_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            dwell_q    <= '0;
            time_q     <= '0;
            phase_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            dwell_q    <= dwell_n;
            time_q     <= time_n;
            phase_done <= done_n;
        end
    end

`ifdef RYG_FADE_EN
    // Ramp level is shared: only one light is ever active, and it restarts at 0 on each entry.
    logic [6:0] lvl_q, lvl_n;

    always_comb begin
        lvl_n = lvl_q;
        if (state_n != state_q)
            lvl_n = '0;
        else if (tick && lvl_q < target)
            lvl_n = lvl_q + 7'd1;
        else if (tick && lvl_q > target)
            lvl_n = lvl_q - 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_q <= '0;
        else     lvl_q <= lvl_n;
    end

    assign duty_src = state_n;
    assign duty_lvl = lvl_n;
`else
    assign duty_src = state_q;
    assign duty_lvl = target;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_duty    <= '0;
            green_duty  <= '0;
            yellow_duty <= '0;
        end else begin
            red_duty    <= (duty_src == RED)    ? duty_lvl : 7'd0;
            green_duty  <= (duty_src == GREEN)  ? duty_lvl : 7'd0;
            yellow_duty <= (duty_src == YELLOW) ? duty_lvl : 7'd0;
        end
    end

endmodule

// File: tb/tb_ryg_pwm_sequencer.sv
// Bench for ryg_pwm_sequencer: phase/duty model checked every cycle plus directed literal checks.
module tb_ryg_pwm_sequencer;
    localparam int TD   = 2;
    localparam int DMAX = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0;
    logic [15:0] red_time = 16'd3, green_time = 16'd2, yellow_time = 16'd1;
    logic [6:0]  brightness = 7'd60;
    logic [6:0]  red_duty, yellow_duty, green_duty;
    logic [1:0]  state;
    logic        phase_done;

    int checks = 0;
    int errors = 0;

    ryg_pwm_sequencer #(.TICK_DIV(TD), .DUTY_MAX(DMAX)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .red_time(red_time), .green_time(green_time), .yellow_time(yellow_time),
        .brightness(brightness),
        .red_duty(red_duty), .yellow_duty(yellow_duty), .green_duty(green_duty),
        .state(state), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase (0 idle,1 red,2 green,3 yellow), clocks remaining in phase, clocks elapsed.
    int m_ph = 0, m_rem = 0, m_el = 0, m_pd = 0, m_lv = 0;
    int m_r = 0, m_g = 0, m_y = 0;

    function automatic int eff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int time_of(input int ph);
        return (ph == 1) ? int'(red_time) : (ph == 2) ? int'(green_time) : int'(yellow_time);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_rem = 0; m_el = 0; m_pd = 0; m_lv = 0;
            m_r = 0; m_g = 0; m_y = 0;
        end else begin
            int prev, br;
            bit tk;
            prev = m_ph;
            br   = (int'(brightness) > DMAX) ? DMAX : int'(brightness);
            tk   = (prev != 0) && (m_el % TD == TD - 1);
            m_pd = 0;
            if (!enable) begin
                m_ph = 0;
            end else if (prev == 0) begin
                m_ph = 1;
                m_rem = eff(time_of(1)) * TD;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ph = (prev == 3) ? 1 : prev + 1;
                    m_rem = eff(time_of(m_ph)) * TD;
                    m_pd = 1;
                end
            end
            m_el = (m_ph != prev) ? 0 : m_el + 1;
`ifdef RYG_FADE_EN
            if (m_ph != prev) m_lv = 0;
            else if (tk && m_lv < br) m_lv++;
            else if (tk && m_lv > br) m_lv--;
            m_r = (m_ph == 1) ? m_lv : 0;
            m_g = (m_ph == 2) ? m_lv : 0;
            m_y = (m_ph == 3) ? m_lv : 0;
`else
            m_r = (prev == 1) ? br : 0;
            m_g = (prev == 2) ? br : 0;
            m_y = (prev == 3) ? br : 0;
`endif
        end
    end

    always @(negedge clk) begin
        chk("state", int'(state), m_ph);
        chk("phase_done", int'(phase_done), m_pd);
        chk("red_duty", int'(red_duty), m_r);
        chk("green_duty", int'(green_duty), m_g);
        chk("yellow_duty", int'(yellow_duty), m_y);
        if ((red_duty != 0) + (green_duty != 0) + (yellow_duty != 0) > 1)
            chk("one_light", 2, 1);
    end

    task automatic wait_for(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(state) != s && n < 200);
        chk("wait_for_state", int'(state), s);
    endtask

    task automatic count_len(input int s, output int n);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (int'(state) != s) break;
            n++;
        end
    endtask

    initial begin
        int n, es, ep, er;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_red", int'(red_duty), 0);
        chk("reset_pd", int'(phase_done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", int'(state), 0);

        // Sequencing 3/2/1 at brightness 60
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            es = (i < 6) ? 1 : (i < 10) ? 2 : (i < 12) ? 3 : (i < 18) ? 1 : (i < 22) ? 2 : 3;
            ep = (i == 6 || i == 10 || i == 12 || i == 18 || i == 22) ? 1 : 0;
            chk("seq_state", int'(state), es);
            chk("seq_pd", int'(phase_done), ep);
`ifndef RYG_FADE_EN
            er = ((i >= 1 && i <= 6) || (i >= 13 && i <= 18)) ? 60 : 0;
            chk("seq_red_duty", int'(red_duty), er);
`endif
        end

        // Latching: red_time changed mid-RED only applies next entry
        wait_for(2);
        wait_for(1);
        red_time = 16'd5;
        count_len(1, n);
        chk("latch_red_cur", n, 6);
        wait_for(1);
        count_len(1, n);
        chk("latch_red_next", n, 10);
        red_time = 16'd3;

        // Boundary: green_time 0 acts as 1 tick; brightness clamps to DUTY_MAX
        green_time = 16'd0;
        brightness = 7'd120;
        wait_for(1);
        wait_for(2);
        count_len(2, n);
        chk("green_zero_len", n, 2);
`ifndef RYG_FADE_EN
        chk("clamp_green_duty", int'(green_duty), 100);
`endif

        // Abort in last RED cycle
        wait_for(1);
        repeat (5) @(negedge clk);
        chk("abort_pre", int'(state), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_state", int'(state), 0);
        chk("abort_pd", int'(phase_done), 0);
        @(negedge clk);
        chk("abort_red_duty", int'(red_duty), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_for(1);
        count_len(1, n);
        chk("restart_red_len", n, 6);

        // Asynchronous reset mid-GREEN
        wait_for(2);
        #1 rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_green", int'(green_duty), 0);
        chk("async_pd", int'(phase_done), 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(state), 0);
        enable = 1'b1;
        wait_for(1);
        count_len(1, n);
        chk("post_rst_red_len", n, 6);

        // Long RED with brightness change mid-phase (model-checked, exercises fade in that build)
        green_time = 16'd2;
        red_time   = 16'd10;
        brightness = 7'd4;
        wait_for(1);
        repeat (12) @(negedge clk);
        brightness = 7'd2;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ryg_pwm_sequencer.md
RYG_PWM_SEQUENCER -- requirements
Module: ryg_pwm_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per dwell tick (1 ms at 100 MHz); legal range 1..2^27-1.
REQ-002 SHALL have parameter DUTY_MAX, default 100, meaning full-scale duty level fed to downstream PWM generators.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  run request; 0 forces IDLE.
REQ-006 SHALL have port red_time, green_time, yellow_time  input  16 each  phase dwell in ticks.
REQ-007 SHALL have port brightness  input  7  requested active-light duty, 0..127.
REQ-008 SHALL have port red_duty, yellow_duty, green_duty  output  7 each  registered duty levels for three PWM generators.
REQ-009 SHALL have port state  output  2  current phase: 00 IDLE, 01 RED, 10 GREEN, 11 YELLOW.
REQ-010 SHALL have port phase_done  output  1  one-cycle pulse on each phase-to-phase transition.

Function
REQ-011 SHALL implement FSM IDLE -> RED -> GREEN -> YELLOW -> RED ..., one transition per clk at most.
REQ-012 SHALL leave IDLE for RED on the first clk edge where enable=1.
REQ-013 SHALL enter IDLE on the next clk edge whenever enable=0, from any state; enable=0 overrides a coincident phase expiry (no phase_done).
REQ-014 SHALL run a 27-bit prescaler counting 0..TICK_DIV-1, asserting internal tick for one cycle when count = TICK_DIV-1 then wrapping to 0; TICK_DIV=1 yields tick every cycle.
REQ-015 SHALL hold prescaler and dwell counter at 0 in IDLE and clear both on every phase entry.
REQ-016 SHALL latch the entered phase's *_time on the entry edge; changes to *_time mid-phase take effect on next entry.
REQ-017 SHALL treat a latched time of 0 as 1.
REQ-018 SHALL increment the 16-bit dwell counter on each tick and transition on the tick where dwell = latched_time-1, giving exactly latched_time ticks per phase.
REQ-019 SHALL pulse phase_done in the cycle state shows the new phase; never on IDLE entry or exit.
REQ-020 SHALL clamp brightness to DUTY_MAX (values > DUTY_MAX use DUTY_MAX).
REQ-021 SHALL drive the inactive lights' duty to 0 and, in IDLE, all three duties to 0.
REQ-022 SHALL update duty outputs with one clk latency from state/brightness change; no two lights nonzero in the same cycle.

Reset
REQ-023 SHALL, while rst=1, immediately force state=00, all duties 0, phase_done 0, prescaler 0, dwell counter 0, latched time 0.
REQ-024 SHALL, after rst release, remain in IDLE until the first edge with enable=1; reset mid-phase discards the phase.

Configuration
REQ-025 SHALL support macro RYG_FADE_EN.
REQ-026 SHALL, with RYG_FADE_EN defined, start the active light at duty 0 on phase entry and step it by 1 per tick toward clamped brightness (up or down, including mid-phase brightness changes), stopping at target; leaving light drops to 0 on transition edge.
REQ-027 SHALL, without RYG_FADE_EN, drive the active light to clamped brightness one clk after entry and follow brightness changes with one clk latency.

Verification (TICK_DIV=2)
REQ-028 Reset: rst=1 pulse mid-GREEN -> state=00, all duties 0 asynchronously; stays IDLE until enable=1.
REQ-029 Sequencing: times 3/2/1, brightness=60, enable=1 -> RED 6 clk, GREEN 4 clk, YELLOW 2 clk, repeat; phase_done pulses at each change; active duty 60, others 0.
REQ-030 Boundaries: green_time=0, brightness=120 -> GREEN lasts 1 tick (2 clk); active duty 100.
REQ-031 Abort: enable=0 in the cycle RED dwell expires -> next state IDLE, no phase_done, duties 0; enable=1 later -> restarts in RED with full red_time.
REQ-032 Latching: change red_time 3->5 mid-RED -> current RED still 3 ticks; next RED 5 ticks.
REQ-033 Fade (RYG_FADE_EN): red_time=10, brightness=4 -> red_duty 0,1,2,3,4 on successive ticks then holds 4; brightness to 2 mid-phase -> 3,2 on next two ticks.
